// File: rtl/axil_adder_array.sv
// AXI4-Lite slave holding NUM_CH operand pairs; a sequential engine adds one pair per cycle
// with signed/unsigned mode, optional saturation, sticky overflow flags and a done status.
module axil_adder_array #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_CH     = 4
) (
    input  logic                    s1_axi_aclk,
    input  logic                    s1_axi_areset,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_awaddr,
    input  logic                    s1_axi_awvalid,
    output logic                    s1_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s1_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_axi_wstrb,
    input  logic                    s1_axi_wvalid,
    output logic                    s1_axi_wready,
    output logic [1:0]              s1_axi_bresp,
    output logic                    s1_axi_bvalid,
    input  logic                    s1_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_axi_araddr,
    input  logic                    s1_axi_arvalid,
    output logic                    s1_axi_arready,
    output logic [DATA_WIDTH-1:0]   s1_axi_rdata,
    output logic [1:0]              s1_axi_rresp,
    output logic                    s1_axi_rvalid,
    input  logic                    s1_axi_rready
);
    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BW = ADDR_WIDTH - 4;
    localparam int WW = ADDR_WIDTH - 2;

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  run_signed_q, run_signed_d, run_sat_q, run_sat_d;
    logic                  ctrl_signed_q, ctrl_signed_d, ctrl_sat_q, ctrl_sat_d;
    logic                  done_q, done_d;
    logic [NUM_CH-1:0]     ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] a_q [NUM_CH];
    logic [DATA_WIDTH-1:0] a_d [NUM_CH];
    logic [DATA_WIDTH-1:0] b_q [NUM_CH];
    logic [DATA_WIDTH-1:0] b_d [NUM_CH];
    logic [DATA_WIDTH-1:0] sum_q [NUM_CH];
    logic [DATA_WIDTH-1:0] sum_d [NUM_CH];
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [WW-1:0]         aw_addr_q, aw_addr_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [SW-1:0]         w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  busy, start_cmd, clr_cmd, wr_err, rd_err;
    logic [DATA_WIDTH-1:0] rd_data, op_a, op_b, eng_sum;
    logic [DATA_WIDTH:0]   sum_ext;
    logic                  eng_ovf;
    logic                  unused_addr_bits;

    assign busy             = (state_q == ST_RUN);
    assign unused_addr_bits = ^{s1_axi_awaddr[1:0], s1_axi_araddr[1:0]};

    assign s1_axi_awready = !aw_held_q && !bvalid_q;
    assign s1_axi_wready  = !w_held_q && !bvalid_q;
    assign s1_axi_arready = !rvalid_q;
    assign s1_axi_bvalid  = bvalid_q;
    assign s1_axi_bresp   = bresp_q;
    assign s1_axi_rvalid  = rvalid_q;
    assign s1_axi_rresp   = rresp_q;
    assign s1_axi_rdata   = rdata_q;

    function automatic logic [DATA_WIDTH-1:0] apply_strb(input logic [DATA_WIDTH-1:0] old_v,
                                                         input logic [DATA_WIDTH-1:0] new_v,
                                                         input logic [SW-1:0] strb);
        logic [DATA_WIDTH-1:0] r;
        r = old_v;
        for (int k = 0; k < SW; k++) begin
            if (strb[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

    // Engine datapath: one extra bit keeps the carry for unsigned overflow.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cnt_q == CW'(i)) begin
                op_a = a_q[i];
                op_b = b_q[i];
            end
        end
        sum_ext = {1'b0, op_a} + {1'b0, op_b};
        if (run_signed_q)
            eng_ovf = (op_a[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                      (sum_ext[DATA_WIDTH-1] != op_a[DATA_WIDTH-1]);
        else
            eng_ovf = sum_ext[DATA_WIDTH];
        eng_sum = sum_ext[DATA_WIDTH-1:0];
        if (run_sat_q && eng_ovf) begin
            if (!run_signed_q)             eng_sum = '1;
            else if (op_a[DATA_WIDTH-1])   eng_sum = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            else                           eng_sum = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b1;
        if (s1_axi_araddr[ADDR_WIDTH-1:2] == WW'(0)) begin
            rd_err     = 1'b0;
            rd_data[1] = ctrl_signed_q;
            rd_data[2] = ctrl_sat_q;
        end else if (s1_axi_araddr[ADDR_WIDTH-1:2] == WW'(1)) begin
            rd_err     = 1'b0;
            rd_data[0] = busy;
            rd_data[1] = done_q;
            for (int i = 0; i < NUM_CH; i++) rd_data[8+i] = ovf_q[i];
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (s1_axi_araddr[ADDR_WIDTH-1:4] == BW'(i + 1)) begin
                    case (s1_axi_araddr[3:2])
                        2'd0:    begin rd_err = 1'b0; rd_data = a_q[i];   end
                        2'd1:    begin rd_err = 1'b0; rd_data = b_q[i];   end
                        2'd2:    begin rd_err = 1'b0; rd_data = sum_q[i]; end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;  cnt_d = cnt_q;
        run_signed_d = run_signed_q;  run_sat_d = run_sat_q;
        ctrl_signed_d = ctrl_signed_q;  ctrl_sat_d = ctrl_sat_q;
        done_d = done_q;  ovf_d = ovf_q;
        a_d = a_q;  b_d = b_q;  sum_d = sum_q;
        aw_held_d = aw_held_q;  aw_addr_d = aw_addr_q;
        w_held_d = w_held_q;  w_data_d = w_data_q;  w_strb_d = w_strb_q;
        bvalid_d = bvalid_q;  bresp_d = bresp_q;
        rvalid_d = rvalid_q;  rresp_d = rresp_q;  rdata_d = rdata_q;
        start_cmd = 1'b0;  clr_cmd = 1'b0;  wr_err = 1'b1;

        if (s1_axi_awvalid && s1_axi_awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = s1_axi_awaddr[ADDR_WIDTH-1:2];
        end
        if (s1_axi_wvalid && s1_axi_wready) begin
            w_held_d = 1'b1;
            w_data_d = s1_axi_wdata;
            w_strb_d = s1_axi_wstrb;
        end
        if (bvalid_q && s1_axi_bready) bvalid_d = 1'b0;

        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            if (aw_addr_q == WW'(0)) begin
                wr_err = 1'b0;
                if (w_strb_q[0]) begin
                    ctrl_signed_d = w_data_q[1];
                    ctrl_sat_d    = w_data_q[2];
                    start_cmd     = w_data_q[0];
                    clr_cmd       = w_data_q[3];
                end
            end else if (aw_addr_q == WW'(1)) begin
                wr_err = !w_data_q[1];
                if (!wr_err && w_strb_q[0]) done_d = 1'b0;
            end else begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (aw_addr_q[WW-1:2] == BW'(i + 1)) begin
                        if (aw_addr_q[1:0] == 2'd0) begin
                            wr_err = busy;
                            if (!busy) a_d[i] = apply_strb(a_q[i], w_data_q, w_strb_q);
                        end else if (aw_addr_q[1:0] == 2'd1) begin
                            wr_err = busy;
                            if (!busy) b_d[i] = apply_strb(b_q[i], w_data_q, w_strb_q);
                        end
                    end
                end
            end
            bresp_d = wr_err ? 2'b10 : 2'b00;
        end

        // Clear is applied first so an overflow on the same edge survives it.
        if (clr_cmd) ovf_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (start_cmd) begin
                    state_d      = ST_RUN;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    run_signed_d = ctrl_signed_d;
                    run_sat_d    = ctrl_sat_d;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (cnt_q == CW'(i)) begin
                        sum_d[i] = eng_sum;
                        if (eng_ovf) ovf_d[i] = 1'b1;
                    end
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(NUM_CH - 1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (s1_axi_arvalid && s1_axi_arready) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_data;
            rresp_d  = rd_err ? 2'b10 : 2'b00;
        end else if (rvalid_q && s1_axi_rready) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge s1_axi_aclk) begin
        if (s1_axi_areset) begin
            state_q <= ST_IDLE;  cnt_q <= '0;
            run_signed_q <= 1'b0;  run_sat_q <= 1'b0;
            ctrl_signed_q <= 1'b0;  ctrl_sat_q <= 1'b0;
            done_q <= 1'b0;  ovf_q <= '0;
            a_q <= '{default: '0};  b_q <= '{default: '0};  sum_q <= '{default: '0};
            aw_held_q <= 1'b0;  aw_addr_q <= '0;
            w_held_q <= 1'b0;  w_data_q <= '0;  w_strb_q <= '0;
            bvalid_q <= 1'b0;  bresp_q <= 2'b00;
            rvalid_q <= 1'b0;  rresp_q <= 2'b00;  rdata_q <= '0;
        end else begin
            state_q <= state_d;  cnt_q <= cnt_d;
            run_signed_q <= run_signed_d;  run_sat_q <= run_sat_d;
            ctrl_signed_q <= ctrl_signed_d;  ctrl_sat_q <= ctrl_sat_d;
            done_q <= done_d;  ovf_q <= ovf_d;
            a_q <= a_d;  b_q <= b_d;  sum_q <= sum_d;
            aw_held_q <= aw_held_d;  aw_addr_q <= aw_addr_d;
            w_held_q <= w_held_d;  w_data_q <= w_data_d;  w_strb_q <= w_strb_d;
            bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
            rvalid_q <= rvalid_d;  rresp_q <= rresp_d;  rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_axil_adder_array.sv
// Directed bench for axil_adder_array: register access, engine runs, overflow/saturation,
// split AW/W timing, error responses and reset abort.
module tb_axil_adder_array;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [AW-1:0]   awaddr, araddr;
    logic            awvalid, awready, wvalid, wready, bvalid, bready;
    logic [DW-1:0]   wdata, rdata;
    logic [DW/8-1:0] wstrb;
    logic [1:0]      bresp, rresp;
    logic            arvalid, arready, rvalid, rready;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    axil_adder_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_CH(NC)) dut (
        .s1_axi_aclk(clk),       .s1_axi_areset(rst),
        .s1_axi_awaddr(awaddr),  .s1_axi_awvalid(awvalid), .s1_axi_awready(awready),
        .s1_axi_wdata(wdata),    .s1_axi_wstrb(wstrb),     .s1_axi_wvalid(wvalid),
        .s1_axi_wready(wready),  .s1_axi_bresp(bresp),     .s1_axi_bvalid(bvalid),
        .s1_axi_bready(bready),  .s1_axi_araddr(araddr),   .s1_axi_arvalid(arvalid),
        .s1_axi_arready(arready), .s1_axi_rdata(rdata),    .s1_axi_rresp(rresp),
        .s1_axi_rvalid(rvalid),  .s1_axi_rready(rready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called and returns on a falling edge.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int guard;
        logic aw_acc, w_acc, got_b;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        guard = 0;
        while ((awvalid || wvalid) && guard < 50) begin
            aw_acc = awvalid && awready;
            w_acc  = wvalid && wready;
            cycle();
            if (aw_acc) awvalid = 1'b0;
            if (w_acc)  wvalid  = 1'b0;
            guard++;
        end
        got_b = 1'b0;
        resp  = 2'b11;
        while (!got_b && guard < 50) begin
            if (bvalid) begin
                resp  = bresp;
                got_b = 1'b1;
            end
            cycle();
            guard++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        check("write_completes", got_b, 1'b1);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
        int guard;
        logic got_r;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        guard = 0;
        while (arvalid && guard < 50) begin
            if (arready) begin
                cycle();
                arvalid = 1'b0;
            end else begin
                cycle();
            end
            guard++;
        end
        got_r = 1'b0;
        data  = '0;
        resp  = 2'b11;
        while (!got_r && guard < 50) begin
            if (rvalid) begin
                data  = rdata;
                resp  = rresp;
                got_r = 1'b1;
            end
            cycle();
            guard++;
        end
        arvalid = 1'b0; rready = 1'b0;
        check("read_completes", got_r, 1'b1);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] exp_resp, input string tag);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
        check(tag, r, exp_resp);
    endtask

    task automatic rd_expect(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        axi_read(addr, d, r);
        check(tag, d, exp);
        check({tag, "_resp"}, r, 2'b00);
    endtask

    task automatic wait_done(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        logic        seen;
        seen = 1'b0;
        for (int p = 0; p < 30 && !seen; p++) begin
            axi_read(8'h04, d, r);
            if (d[1]) seen = 1'b1;
        end
        check(tag, seen, 1'b1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic        seen;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Idle outputs and register contents after reset
        check("rst_awready", awready, 1'b1);
        check("rst_wready",  wready,  1'b1);
        check("rst_arready", arready, 1'b1);
        check("rst_bvalid",  bvalid,  1'b0);
        check("rst_rvalid",  rvalid,  1'b0);
        check("rst_bresp",   bresp,   2'b00);
        check("rst_rresp",   rresp,   2'b00);
        check("rst_rdata",   rdata,   32'h0);
        rd_expect(8'h00, 32'h0, "rst_ctrl");
        rd_expect(8'h04, 32'h0, "rst_status");
        rd_expect(8'h10, 32'h0, "rst_a0");
        rd_expect(8'h14, 32'h0, "rst_b0");
        rd_expect(8'h18, 32'h0, "rst_sum0");

        // Basic unsigned add on channel 0
        wr(8'h10, 32'h0000AABB, 2'b00, "wr_a0");
        wr(8'h14, 32'h0000CCDD, 2'b00, "wr_b0");
        wr(8'h00, 32'h1, 2'b00, "wr_start1");
        axi_read(8'h04, d, r);
        check("busy_after_start", d[0], 1'b1);
        wait_done("done_run1");
        rd_expect(8'h04, 32'h00000002, "status_run1");
        rd_expect(8'h18, 32'h00017798, "sum0_run1");
        rd_expect(8'h00, 32'h0, "ctrl_start_reads0");

        // Unsigned wrap, then saturation, then overflow clear on channel 1
        wr(8'h20, 32'hFFFFFFFF, 2'b00, "wr_a1");
        wr(8'h24, 32'h00000002, 2'b00, "wr_b1");
        wr(8'h00, 32'h1, 2'b00, "wr_start2");
        wait_done("done_run2");
        rd_expect(8'h28, 32'h00000001, "sum1_wrap");
        rd_expect(8'h04, 32'h00000202, "status_ovf1");
        wr(8'h00, 32'h5, 2'b00, "wr_start_sat");
        wait_done("done_run3");
        rd_expect(8'h28, 32'hFFFFFFFF, "sum1_sat");
        rd_expect(8'h00, 32'h00000004, "ctrl_sat_bit");
        wr(8'h00, 32'h8, 2'b00, "wr_ovf_clr");
        rd_expect(8'h04, 32'h00000002, "status_ovf_cleared");

        // Signed overflow on channel 2, then signed saturation both ways
        wr(8'h30, 32'h7FFFFFFF, 2'b00, "wr_a2");
        wr(8'h34, 32'h00000001, 2'b00, "wr_b2");
        wr(8'h00, 32'h3, 2'b00, "wr_start_signed");
        wait_done("done_run4");
        rd_expect(8'h38, 32'h80000000, "sum2_signed_wrap");
        rd_expect(8'h04, 32'h00000402, "status_ovf2");
        wr(8'h40, 32'h80000000, 2'b00, "wr_a3");
        wr(8'h44, 32'hFFFFFFFF, 2'b00, "wr_b3");
        wr(8'h00, 32'h7, 2'b00, "wr_start_signed_sat");
        wait_done("done_run5");
        rd_expect(8'h38, 32'h7FFFFFFF, "sum2_signed_sat_pos");
        rd_expect(8'h48, 32'h80000000, "sum3_signed_sat_neg");
        rd_expect(8'h28, 32'h00000001, "sum1_signed_no_ovf");
        rd_expect(8'h04, 32'h00000C02, "status_ovf2_ovf3");

        // AW three cycles ahead of W, bready held low for five cycles
        awaddr = 8'h40; awvalid = 1'b1; bready = 1'b0;
        check("aw_first_awready", awready, 1'b1);
        cycle();
        awvalid = 1'b0;
        check("awready_low_after_aw", awready, 1'b0);
        cycle();
        cycle();
        check("awready_low_waiting_w", awready, 1'b0);
        check("bvalid_low_waiting_w", bvalid, 1'b0);
        wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1;
        check("late_w_wready", wready, 1'b1);
        cycle();
        wvalid = 1'b0;
        seen = 1'b0;
        for (int g = 0; g < 10 && !seen; g++) begin
            if (bvalid) seen = 1'b1;
            else cycle();
        end
        check("split_bvalid_seen", seen, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("bvalid_held", bvalid, 1'b1);
            check("bresp_held", bresp, 2'b00);
            check("awready_during_b", awready, 1'b0);
        end
        bready = 1'b1;
        cycle();
        bready = 1'b0;
        check("bvalid_after_b", bvalid, 1'b0);
        check("awready_after_b", awready, 1'b1);
        check("wready_after_b", wready, 1'b1);
        rd_expect(8'h40, 32'h12345678, "a3_split_write");

        // Byte strobes on an operand register
        axi_write(8'h44, 32'hDEADBEEF, 4'b0011, r);
        check("strb_resp", r, 2'b00);
        rd_expect(8'h44, 32'hFFFFBEEF, "b3_strobed");

        // Error responses
        axi_read(8'hFC, d, r);
        check("rd_unmapped_resp", r, 2'b10);
        check("rd_unmapped_data", d, 32'h0);
        axi_read(8'h08, d, r);
        check("rd_gap_resp", r, 2'b10);
        wr(8'h18, 32'h55, 2'b10, "wr_sum0_err");
        rd_expect(8'h18, 32'h00017798, "sum0_unchanged");
        wr(8'h04, 32'h0, 2'b10, "wr_status_bit1_0_err");
        wr(8'hF0, 32'h1, 2'b10, "wr_unmapped_err");
        wr(8'h04, 32'h2, 2'b00, "wr_done_w1c");
        rd_expect(8'h04, 32'h00000C00, "status_done_cleared");
        wr(8'h00, 32'h1, 2'b00, "wr_start_busy_test");
        wr(8'h10, 32'h11111111, 2'b10, "wr_a0_busy_err");
        wait_done("done_run6");
        rd_expect(8'h10, 32'h0000AABB, "a0_unchanged_busy");

        // Reset in the middle of a run
        wr(8'h00, 32'h1, 2'b00, "wr_start_abort");
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("abort_bvalid", bvalid, 1'b0);
        check("abort_awready", awready, 1'b1);
        rd_expect(8'h04, 32'h0, "abort_status");
        rd_expect(8'h18, 32'h0, "abort_sum0");
        rd_expect(8'h10, 32'h0, "abort_a0");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
